// File: rtl/minmax_compare_sequencer_pkg.sv
// Shared types and comparator flag decode for consumers of the 4-bit subtract-compare block.
// Flags come from a-b: lt/gt are signed and use n^v.
package minmax_compare_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMPMAX = 2'd1,
      CMPMIN = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic f_lt(input logic n, input logic v);
      return n ^ v;
   endfunction

   function automatic logic f_gt(input logic n, input logic v, input logic z);
      return ~(n ^ v) & ~z;
   endfunction

   function automatic logic f_eq(input logic z);
      return z;
   endfunction

endpackage

// File: rtl/minmax_compare_sequencer.sv
// Drives each sample against the stored max, then the stored min, through one shared comparator.
// Tracks the signed running max/min of a frame and hands {max,min} out on valid/ready.
module minmax_compare_sequencer
   import minmax_compare_sequencer_pkg::*;
#(
   parameter int W         = 4,
   parameter int FRAME_LEN = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic [W-1:0] cmp_a,
   output logic [W-1:0] cmp_b,
   input  logic         cmp_v,
   input  logic         cmp_n,
   input  logic         cmp_z,
   output logic         out_valid,
   output logic [W-1:0] out_max,
   output logic [W-1:0] out_min,
   input  logic         out_ready
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   sample_r, max_r, min_r;
   logic           first, lt, gt;

   // The first sample of a frame seeds max/min but still walks both compare cycles.
   assign first = (cnt == '0);
   assign lt    = f_lt(cmp_n, cmp_v);
   assign gt    = f_gt(cmp_n, cmp_v, cmp_z);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sample_r  <= '0;
         max_r     <= '0;
         min_r     <= '0;
         in_ready  <= 1'b0;
         cmp_a     <= '0;
         cmp_b     <= '0;
         out_valid <= 1'b0;
         out_max   <= '0;
         out_min   <= '0;
      end else if (clr) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         cmp_a     <= '0;
         cmp_b     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  sample_r <= in_data;
                  cmp_a    <= in_data;
                  cmp_b    <= max_r;
                  in_ready <= 1'b0;
                  state    <= CMPMAX;
               end
            end
            CMPMAX: begin
               if (first || gt) max_r <= sample_r;
               cmp_b <= min_r;
               state <= CMPMIN;
            end
            CMPMIN: begin
               if (first || lt) min_r <= sample_r;
               cnt   <= cnt + CW'(1);
               cmp_a <= '0;
               cmp_b <= '0;
               if (cnt + CW'(1) == LAST) begin
                  // max_r already settled last cycle; min is resolved here
                  out_valid <= 1'b1;
                  out_max   <= max_r;
                  out_min   <= (first || lt) ? sample_r : min_r;
                  state     <= DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  cnt       <= '0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_minmax_compare_sequencer.sv
// Bench for minmax_compare_sequencer with a behavioural subtract-compare responder.
// Fixed frame vectors, multi-cycle corner sequences, and random frames against a max/min model.
module tb_minmax_compare_sequencer;

   localparam int W = 4;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst, clr, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_data, cmp_a, cmp_b, out_max, out_min;
   logic cmp_v, cmp_n, cmp_z;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   minmax_compare_sequencer #(.W(W), .FRAME_LEN(N)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_v(cmp_v), .cmp_n(cmp_n), .cmp_z(cmp_z),
      .out_valid(out_valid), .out_max(out_max), .out_min(out_min), .out_ready(out_ready)
   );

   // comparator responder: a-b with two's complement flags
   logic [W-1:0] diff;
   always_comb begin
      diff  = cmp_a - cmp_b;
      cmp_n = diff[W-1];
      cmp_z = (diff == '0);
      cmp_v = (cmp_a[W-1] != cmp_b[W-1]) && (diff[W-1] != cmp_a[W-1]);
   end

   // records whether the -8 vs 7 overflow compare was ever driven
   bit saw_ovf = 1'b0;
   always @(negedge clk)
      if (cmp_a == 4'h8 && cmp_b == 4'h7 && cmp_v && !cmp_n) saw_ovf <= 1'b1;

   typedef logic [W-1:0] frame_t [N];
   typedef struct {
      string  name;
      frame_t s;
      logic [W-1:0] exp_max;
      logic [W-1:0] exp_min;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void ref_minmax(input frame_t s, output logic [W-1:0] mx,
                                      output logic [W-1:0] mn);
      int hi = -1000, lo = 1000;
      for (int i = 0; i < N; i++) begin
         int x = int'($signed(s[i]));
         if (x > hi) hi = x;
         if (x < lo) lo = x;
      end
      mx = W'(hi);
      mn = W'(lo);
   endfunction

   task automatic send(input logic [W-1:0] v);
      int t = 0;
      while (!in_ready && t < 40) begin @(negedge clk); t++; end
      if (!in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom_range(0, 15);
   endtask

   task automatic wait_out(input string name);
      int t = 0;
      while (!out_valid && t < 40) begin @(negedge clk); t++; end
      chk({name, "_out_valid"}, {3'b0, out_valid}, 4'h1);
   endtask

   task automatic finish_frame(input string name, input logic [W-1:0] mx, input logic [W-1:0] mn);
      wait_out(name);
      chk({name, "_max"}, out_max, mx);
      chk({name, "_min"}, out_min, mn);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_valid_drop"}, {3'b0, out_valid}, 4'h0);
   endtask

   task automatic send_frame(input frame_t s, input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send(s[i]);
      end
   endtask

   vec_t vecs[3];
   frame_t fr;
   logic [W-1:0] mx, mn;

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      vecs[0] = '{"mixed",  '{4'h3, 4'hE, 4'h7, 4'h0, 4'h8, 4'h5, 4'h5, 4'h1}, 4'h7, 4'h8};
      vecs[1] = '{"ovf",    '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h8}, 4'h7, 4'h8};
      vecs[2] = '{"equal",  '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5}, 4'h5, 4'h5};

      repeat (3) @(negedge clk);
      chk("rst_in_ready", {3'b0, in_ready}, 4'h0);
      chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
      chk("rst_out_max", out_max, 4'h0);
      chk("rst_out_min", out_min, 4'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", {3'b0, in_ready}, 4'h1);

      for (int k = 0; k < 3; k++) begin
         send_frame(vecs[k].s, 1'b0);
         finish_frame(vecs[k].name, vecs[k].exp_max, vecs[k].exp_min);
      end
      chk("ovf_lt_compare", {3'b0, saw_ovf}, 4'h1);

      // back-pressure in DONE
      send_frame(vecs[0].s, 1'b0);
      wait_out("bp");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", {3'b0, out_valid}, 4'h1);
         chk("bp_max", out_max, 4'h7);
         chk("bp_min", out_min, 4'h8);
         chk("bp_in_ready", {3'b0, in_ready}, 4'h0);
         chk("bp_cmp_a", cmp_a, 4'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_valid", {3'b0, out_valid}, 4'h0);
      chk("bp_release_in_ready", {3'b0, in_ready}, 4'h1);

      // clr mid-frame: extremes sent before clr must not leak
      send(4'h7); send(4'h7); send(4'h8);
      clr = 1'b1;
      in_valid = 1'b1; in_data = 4'h6;
      @(negedge clk);
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_in_ready", {3'b0, in_ready}, 4'h1);
      chk("clr_out_valid", {3'b0, out_valid}, 4'h0);
      fr = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
      send_frame(fr, 1'b0);
      finish_frame("clr_frame", 4'h3, 4'hC);

      // rst during CMPMIN of the 5th sample
      for (int i = 0; i < 5; i++) send(4'h6);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", {3'b0, out_valid}, 4'h0);
      chk("mid_rst_out_max", out_max, 4'h0);
      chk("mid_rst_out_min", out_min, 4'h0);
      chk("mid_rst_in_ready", {3'b0, in_ready}, 4'h0);
      chk("mid_rst_cmp_b", cmp_b, 4'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_rel_ready", {3'b0, in_ready}, 4'h1);
      fr = '{4'h2, 4'h9, 4'h4, 4'h1, 4'hB, 4'h0, 4'h6, 4'h3};
      ref_minmax(fr, mx, mn);
      send_frame(fr, 1'b0);
      finish_frame("post_rst", mx, mn);

      // random frames against the reference model
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) fr[i] = W'($urandom_range(0, 15));
         ref_minmax(fr, mx, mn);
         send_frame(fr, 1'b1);
         wait_out("rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("rnd_max", out_max, mx);
         chk("rnd_min", out_min, mn);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
